// File: rtl/ddr_sync_ctrl.sv
// ddr_sync_ctrl: start-up and DLL code-update sequencer for the DDR I/O clock tree.
// Drives the freeze/stop/reset/pause/update handshake from a free-running slow clock,
// acknowledges code updates, and counts lock-loss events seen once the interface is up.
// Optional feature macro: DDR_SYNC_AUTO_UPDATE_EN adds a periodic auto-update timer in READY.

module ddr_sync_ctrl #(
   parameter int unsigned NUM_LANES  = 2,
   parameter int unsigned T_SHORT    = 4,
   parameter int unsigned T_LONG     = 8,
   parameter int unsigned T_LOCK     = 6,
   parameter int unsigned UPD_PERIOD = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 start_clk,
   input  logic                 rst,
   input  logic                 dll_lock,
   input  logic                 pll_lock,
   input  logic                 update,
   output logic [NUM_LANES-1:0] pause,
   output logic                 stop,
   output logic                 freeze,
   output logic                 uddcntln,
   output logic                 dll_rst,
   output logic                 ddr_rst,
   output logic                 ready,
   output logic                 update_done,
   output logic [7:0]           relock_cnt
);

   typedef enum logic [3:0] {
      StResetWait, StLockWait, StFreeze, StStop, StDdrRst, StStop2, StFreeze2, StSettle,
      StPause1, StUdd, StPause2, StSettle2, StReady, StUpdPause, StUpdUdd, StUpdPause2
   } state_e;

   localparam logic [CNT_W-1:0] ShortLast = CNT_W'(T_SHORT - 1);
   localparam logic [CNT_W-1:0] LongLast  = CNT_W'(T_LONG - 1);
   localparam logic [CNT_W-1:0] LockVal   = CNT_W'(T_LOCK);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic             sync1_q, lock_s;
   logic             lock_ok, short_done, long_done, upd_req;
   logic             relock_inc, done_set;
   logic             pause_d, stop_d, freeze_d, udd_n_d, dll_rst_d, ddr_rst_d, ready_d;

   // Two-flop lock synchroniser; held clear while the DLL sits in reset so a stale lock is
   // never trusted and LOCK_WAIT always sees a fresh rising edge.
   always_ff @(posedge start_clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else if (state_q == StResetWait) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_q <= dll_lock & pll_lock;
         lock_s  <= sync1_q;
      end
   end

   // Consecutive-lock counter, saturating at T_LOCK and cleared by any lock drop.
   always_comb begin
      stable_d = '0;
      if (lock_s) begin
         stable_d = (stable_q >= LockVal) ? LockVal : stable_q + CNT_W'(1);
      end
   end

   // Stable counter register.
   always_ff @(posedge start_clk or posedge rst) begin
      if (rst) begin
         stable_q <= '0;
      end else begin
         stable_q <= stable_d;
      end
   end

   assign lock_ok    = (stable_d == LockVal);
   assign short_done = (phase_q == ShortLast);
   assign long_done  = (phase_q == LongLast);

`ifdef DDR_SYNC_AUTO_UPDATE_EN
   logic [CNT_W-1:0] timer_q;

   // Auto-update timer: runs only while staying in READY, restarts from 0 on every entry.
   always_ff @(posedge start_clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else if ((state_q == StReady) && (state_d == StReady)) begin
         timer_q <= timer_q + CNT_W'(1);
      end else begin
         timer_q <= '0;
      end
   end

   assign upd_req = update | (timer_q == CNT_W'(UPD_PERIOD - 1));
`else
   logic unused_upd_period;

   assign unused_upd_period = ^CNT_W'(UPD_PERIOD);
   assign upd_req           = update;
`endif

   // Next-state logic; lock loss is only acted on in READY and the UPD_* states.
   always_comb begin
      state_d    = state_q;
      relock_inc = 1'b0;
      done_set   = 1'b0;
      case (state_q)
         StResetWait: if (short_done) state_d = StLockWait;
         StLockWait:  if (lock_ok)    state_d = StFreeze;
         StFreeze:    if (short_done) state_d = StStop;
         StStop:      if (short_done) state_d = StDdrRst;
         StDdrRst:    if (short_done) state_d = StStop2;
         StStop2:     if (short_done) state_d = StFreeze2;
         StFreeze2:   if (short_done) state_d = StSettle;
         StSettle:    if (long_done)  state_d = StPause1;
         StPause1:    if (short_done) state_d = StUdd;
         StUdd:       if (short_done) state_d = StPause2;
         StPause2:    if (short_done) state_d = StSettle2;
         StSettle2:   if (long_done)  state_d = StReady;
         StReady: begin
            if (!lock_s) begin
               state_d    = StLockWait;
               relock_inc = 1'b1;
            end else if (upd_req) begin
               state_d = StUpdPause;
            end
         end
         StUpdPause, StUpdUdd, StUpdPause2: begin
            if (!lock_s) begin
               state_d    = StLockWait;
               relock_inc = 1'b1;
            end else if (short_done) begin
               case (state_q)
                  StUpdPause: state_d = StUpdUdd;
                  StUpdUdd:   state_d = StUpdPause2;
                  default: begin
                     state_d  = StReady;
                     done_set = 1'b1;
                  end
               endcase
            end
         end
         default: state_d = StResetWait;
      endcase
   end

   // State register and phase counter; the phase counter restarts on every state change.
   always_ff @(posedge start_clk or posedge rst) begin
      if (rst) begin
         state_q <= StResetWait;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= (state_d != state_q) ? '0 : phase_q + CNT_W'(1);
      end
   end

   // Output decode from the next state so registered outputs switch with the state.
   always_comb begin
      pause_d   = 1'b0;
      stop_d    = 1'b0;
      freeze_d  = 1'b0;
      udd_n_d   = 1'b1;
      dll_rst_d = 1'b0;
      ddr_rst_d = 1'b0;
      ready_d   = 1'b0;
      case (state_d)
         StResetWait: begin
            dll_rst_d = 1'b1;
            ddr_rst_d = 1'b1;
         end
         StFreeze, StFreeze2: freeze_d = 1'b1;
         StStop, StStop2: begin
            freeze_d = 1'b1;
            stop_d   = 1'b1;
         end
         StDdrRst: begin
            freeze_d  = 1'b1;
            stop_d    = 1'b1;
            ddr_rst_d = 1'b1;
         end
         StPause1, StPause2, StUpdPause, StUpdPause2: pause_d = 1'b1;
         StUdd, StUpdUdd: begin
            pause_d = 1'b1;
            udd_n_d = 1'b0;
         end
         StReady: ready_d = 1'b1;
         default: ;
      endcase
   end

   // Output registers, update acknowledge pulse and saturating lock-loss counter.
   always_ff @(posedge start_clk or posedge rst) begin
      if (rst) begin
         pause       <= '0;
         stop        <= 1'b0;
         freeze      <= 1'b0;
         uddcntln    <= 1'b1;
         dll_rst     <= 1'b1;
         ddr_rst     <= 1'b1;
         ready       <= 1'b0;
         update_done <= 1'b0;
         relock_cnt  <= 8'd0;
      end else begin
         pause       <= {NUM_LANES{pause_d}};
         stop        <= stop_d;
         freeze      <= freeze_d;
         uddcntln    <= udd_n_d;
         dll_rst     <= dll_rst_d;
         ddr_rst     <= ddr_rst_d;
         ready       <= ready_d;
         update_done <= done_set;
         if (relock_inc && (relock_cnt != 8'hFF)) begin
            relock_cnt <= relock_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ddr_sync_ctrl.sv
// tb_ddr_sync_ctrl: directed bench for ddr_sync_ctrl with a phase-table reference model.
// The model follows the macro DDR_SYNC_AUTO_UPDATE_EN exactly like the design.

module tb_ddr_sync_ctrl;

   localparam int unsigned NL  = 8;
   localparam int unsigned TS  = 4;
   localparam int unsigned TLG = 8;
   localparam int unsigned TLK = 6;
   localparam int unsigned UPP = 64;
   localparam int          SU_LEN = 8 * TS + 2 * TLG;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dll_lock = 1'b1;
   logic          pll_lock = 1'b1;
   logic          update = 1'b0;
   logic [NL-1:0] pause;
   logic          stop, freeze, uddcntln, dll_rst, ddr_rst, ready, update_done;
   logic [7:0]    relock_cnt;

   int n_pass = 0;
   int n_tot  = 0;
   bit cmp_en = 1'b0;

   ddr_sync_ctrl #(
      .NUM_LANES (NL),
      .T_SHORT   (TS),
      .T_LONG    (TLG),
      .T_LOCK    (TLK),
      .UPD_PERIOD(UPP),
      .CNT_W     (16)
   ) dut (
      .start_clk  (clk),
      .rst        (rst),
      .dll_lock   (dll_lock),
      .pll_lock   (pll_lock),
      .update     (update),
      .pause      (pause),
      .stop       (stop),
      .freeze     (freeze),
      .uddcntln   (uddcntln),
      .dll_rst    (dll_rst),
      .ddr_rst    (ddr_rst),
      .ready      (ready),
      .update_done(update_done),
      .relock_cnt (relock_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: mode 0 reset wait, 1 lock wait, 2 start-up run, 3 ready, 4 update run.
   int m_mode = 0, m_t = 0, m_stable = 0, m_relock = 0, m_ns = 0, m_next = 0;
   bit m_s1 = 0, m_ls = 0, m_done = 0, m_auto;
   int lens [10] = '{TS, TS, TS, TS, TS, TLG, TS, TS, TS, TLG};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_t = 0; m_stable = 0; m_relock = 0;
         m_s1 = 0; m_ls = 0; m_done = 0;
      end else begin
`ifdef DDR_SYNC_AUTO_UPDATE_EN
         m_auto = (m_mode == 3) && (m_t == UPP - 1);
`else
         m_auto = 0;
`endif
         m_ns   = m_ls ? ((m_stable + 1 > TLK) ? TLK : m_stable + 1) : 0;
         m_done = 0;
         m_next = m_mode;
         case (m_mode)
            0: if (m_t == TS - 1) m_next = 1;
            1: if (m_ns == TLK) m_next = 2;
            2: if (m_t == SU_LEN - 1) m_next = 3;
            3: begin
               if (!m_ls) begin
                  m_next = 1;
                  if (m_relock < 255) m_relock++;
               end else if (update || m_auto) m_next = 4;
            end
            default: begin
               if (!m_ls) begin
                  m_next = 1;
                  if (m_relock < 255) m_relock++;
               end else if (m_t == 3 * TS - 1) begin
                  m_next = 3;
                  m_done = 1;
               end
            end
         endcase
         if (m_mode == 0) begin
            m_ls = 0; m_s1 = 0;
         end else begin
            m_ls = m_s1; m_s1 = dll_lock & pll_lock;
         end
         m_t      = (m_next != m_mode) ? 0 : m_t + 1;
         m_mode   = m_next;
         m_stable = m_ns;
      end
   end

   // Cycle-by-cycle comparison of all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      logic ep, es, ef, eu, edr, edd, erd;
      int   acc, idx;
      if (cmp_en) begin
         ep = 0; es = 0; ef = 0; eu = 1; edr = 0; edd = 0; erd = 0;
         case (m_mode)
            0: begin edr = 1; edd = 1; end
            2: begin
               acc = 0; idx = 0;
               for (int i = 0; i < 10; i++) begin
                  if (m_t >= acc && m_t < acc + lens[i]) idx = i;
                  acc += lens[i];
               end
               case (idx)
                  0, 4: ef = 1;
                  1, 3: begin ef = 1; es = 1; end
                  2:    begin ef = 1; es = 1; edd = 1; end
                  6, 8: ep = 1;
                  7:    begin ep = 1; eu = 0; end
                  default: ;
               endcase
            end
            3: erd = 1;
            4: begin
               ep = 1;
               eu = !(m_t >= TS && m_t < 2 * TS);
            end
            default: ;
         endcase
         chk("cycle_outputs",
             {9'd0, pause, stop, freeze, uddcntln, dll_rst, ddr_rst, ready, update_done,
              relock_cnt},
             {9'd0, {NL{ep}}, es, ef, eu, edr, edd, erd, m_done, 8'(m_relock)});
      end
   end

   task automatic wait_ready(input int bound, output int n, output int dn);
      n = 0; dn = 0;
      while (ready !== 1'b1 && n < bound) begin
         step();
         n++;
         if (update_done) dn++;
      end
      chk("wait_ready_bound", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, dn, dn2, c_frz, c_udd, c_pau, first_rdy, lo, hi, dcnt;
      repeat (3) step();
      cmp_en = 1'b1;
      chk("reset_outputs",
          {9'd0, pause, stop, freeze, uddcntln, dll_rst, ddr_rst, ready, update_done, relock_cnt},
          {9'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});

      // Start-up with lock already high.
      rst = 1'b0;
      c_frz = 0; c_udd = 0; c_pau = 0; first_rdy = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (freeze) c_frz++;
         if (!uddcntln) c_udd++;
         if (pause[0]) c_pau++;
         if (ready && first_rdy < 0) first_rdy = i;
      end
      chk("startup_ready_cycle", first_rdy, 60);
      chk("startup_freeze_width", c_frz, 20);
      chk("startup_udd_width", c_udd, 4);
      chk("startup_pause_width", c_pau, 12);

      // Single-cycle update request.
      update = 1'b1;
      step();
      update = 1'b0;
      chk("upd_pause_all_lanes", {24'd0, pause}, 32'h0000_00FF);
      lo = 1; dcnt = 0; c_udd = 0; first_rdy = -1;
      for (int j = 2; j <= 20; j++) begin
         step();
         if (!ready) lo++;
         if (!uddcntln) begin
            c_udd++;
            if (first_rdy < 0) first_rdy = j;
         end
         if (update_done) dcnt++;
      end
      chk("upd_ready_low", lo, 12);
      chk("upd_udd_first", first_rdy, 5);
      chk("upd_udd_width", c_udd, 4);
      chk("upd_done_pulses", dcnt, 1);
      chk("upd_relock", relock_cnt, 0);

      // Lock drop in READY for three cycles.
      dll_lock = 1'b0;
      repeat (3) step();
      chk("drop_ready_low", {31'd0, ready}, 32'd0);
      chk("drop_relock", relock_cnt, 1);
      dll_lock = 1'b1;
      wait_ready(100, n, dn);
      chk("drop_resequence_len", n, 56);

      // PLL lock lost during the code-update phase of an update.
      update = 1'b1;
      step();
      update = 1'b0;
      repeat (4) step();
      chk("upd_udd_reached", {31'd0, uddcntln}, 32'd0);
      pll_lock = 1'b0;
      dn = 0;
      repeat (3) begin
         step();
         if (update_done) dn++;
      end
      chk("abort_lockwait", {23'd0, pause, ready}, 32'd0);
      chk("abort_relock", relock_cnt, 2);
      pll_lock = 1'b1;
      wait_ready(100, n, dn2);
      chk("abort_no_done", dn + dn2, 0);
      chk("abort_resequence_len", n, 56);

      // Update held high: back-to-back updates with one READY cycle between.
      update = 1'b1;
      hi = 0; dcnt = 0;
      for (int k = 1; k <= 39; k++) begin
         step();
         if (ready) hi++;
         if (update_done) dcnt++;
      end
      update = 1'b0;
      chk("held_ready_cycles", hi, 3);
      chk("held_done_pulses", dcnt, 3);
      chk("held_in_ready", {31'd0, ready}, 32'd1);

`ifdef DDR_SYNC_AUTO_UPDATE_EN
      for (int r = 0; r < 2; r++) begin
         n = 0;
         while (ready && n < 200) begin
            step();
            n++;
         end
         chk("auto_update_delay", n, 64);
         wait_ready(100, n, dn);
         chk("auto_update_done", dn, 1);
      end
`else
      hi = 0;
      repeat (200) begin
         step();
         if (ready) hi++;
      end
      chk("no_auto_ready_held", hi, 200);
`endif

      // Repeated lock drops saturate the relock counter.
      repeat (300) begin
         dll_lock = 1'b0;
         repeat (3) step();
         dll_lock = 1'b1;
         wait_ready(100, n, dn);
      end
      chk("relock_saturated", relock_cnt, 255);

      // Reset asserted while in DDR_RST clears everything at once.
      dll_lock = 1'b0;
      repeat (3) step();
      dll_lock = 1'b1;
      repeat (17) step();
      chk("in_ddr_rst", {29'd0, freeze, stop, ddr_rst}, 32'd7);
      chk("in_ddr_rst_relock", relock_cnt, 255);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_values",
          {9'd0, pause, stop, freeze, uddcntln, dll_rst, ddr_rst, ready, update_done, relock_cnt},
          {9'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
